// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter that shares the single register-file write port among
//   four requesters. Each transaction runs IDLE -> GRANT -> WRITE -> IDLE.
//   The owner's 2-bit register address is decoded to a one-hot select and its
//   data is latched for a one-cycle write strobe.
//
//   Optional feature (macro RF_ARB_LOCK_EN): an owner that keeps req high may
//   issue up to BURST_MAX back-to-back writes (WRITE -> GRANT -> WRITE) before
//   the port is rearbitrated.
//
// Ports
//   clk      system clock, all state on the rising edge
//   rst_n    asynchronous active-low reset
//   req      request per requester (bit i = requester i)
//   addr     packed 2-bit register addresses, addr[2i+1:2i] = requester i
//   wdata    packed write data, wdata[DATA_W*i +: DATA_W] = requester i
//   gnt      one-hot current owner, 0000 when idle
//   gnt_id   binary index of current owner
//   ack      one-cycle one-hot pulse to the owner when its write happens
//   wr_en    register-file write strobe
//   wr_sel   one-hot register select (holds its value outside WRITE)
//   wr_data  register-file write data (holds its value outside WRITE)
//   busy     high whenever the FSM is not IDLE
module rf_write_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [7:0]            addr,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [3:0]            gnt,
  output logic [1:0]            gnt_id,
  output logic [3:0]            ack,
  output logic                  wr_en,
  output logic [3:0]            wr_sel,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy
);

  if (BURST_MAX < 1) begin : g_bad_burst
    $error("BURST_MAX must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          ptr, ptr_nxt;
  logic [3:0]          gnt_nxt, ack_nxt, wr_sel_nxt;
  logic [1:0]          gnt_id_nxt;
  logic                wr_en_nxt;
  logic [DATA_W-1:0]   wr_data_nxt;
  logic [1:0]          owner_addr;
  logic [DATA_W-1:0]   owner_data;

`ifdef RF_ARB_LOCK_EN
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [BW-1:0]       burst_cnt, burst_cnt_nxt;
`endif

  // First requester with req high, searching upward from p+1 (mod 4).
  // Iterating k from 4 down to 1 lets the smallest offset win last.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] a);
    decode = 4'b0001 << a;
  endfunction

  // Owner's address and data slices, selected by the registered owner index.
  always_comb begin
    owner_addr = 2'b00;
    owner_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_id == 2'(i)) begin
        owner_addr = addr[2*i +: 2];
        owner_data = wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    ack_nxt     = 4'b0000;
    wr_en_nxt   = 1'b0;
    wr_sel_nxt  = wr_sel;
    wr_data_nxt = wr_data;
`ifdef RF_ARB_LOCK_EN
    burst_cnt_nxt = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_id_nxt = rr_pick(ptr, req);
          gnt_nxt    = decode(gnt_id_nxt);
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (req[gnt_id]) begin
          wr_sel_nxt  = decode(owner_addr);
          wr_data_nxt = owner_data;
          wr_en_nxt   = 1'b1;
          ack_nxt     = gnt;
          state_nxt   = WRITE;
`ifdef RF_ARB_LOCK_EN
          burst_cnt_nxt = burst_cnt + BW'(1);
`endif
        end else begin
          // Owner withdrew before its write: release without moving the pointer.
          gnt_nxt   = 4'b0000;
          state_nxt = IDLE;
`ifdef RF_ARB_LOCK_EN
          burst_cnt_nxt = '0;
`endif
        end
      end
      WRITE: begin
`ifdef RF_ARB_LOCK_EN
        // burst_cnt already counts the write just performed.
        if (req[gnt_id] && (burst_cnt < BW'(BURST_MAX))) begin
          state_nxt = GRANT;
        end else begin
          ptr_nxt       = gnt_id;
          gnt_nxt       = 4'b0000;
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
        end
`else
        ptr_nxt   = gnt_id;
        gnt_nxt   = 4'b0000;
        state_nxt = IDLE;
`endif
      end
      default: begin
        gnt_nxt   = 4'b0000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      gnt     <= 4'b0000;
      gnt_id  <= 2'b00;
      ack     <= 4'b0000;
      wr_en   <= 1'b0;
      wr_sel  <= 4'b0000;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      ack     <= ack_nxt;
      wr_en   <= wr_en_nxt;
      wr_sel  <= wr_sel_nxt;
      wr_data <= wr_data_nxt;
    end
  end

`ifdef RF_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt <= '0;
    else        burst_cnt <= burst_cnt_nxt;
  end
`endif

  assign busy = (state != IDLE);

endmodule
